genaxis_pkt_former: RTL
=======================

# genaxis_pkt_former

Consumes the random descriptors produced by the LFSR generator stage (length, channel, data, pause) and forms AXI-Stream packets from them. Clamps each descriptor into the programmed [min, max] window, emits the packet beat by beat under tready backpressure, then idles for the pause interval. Sits between the LFSR generator and the generator's AXIS master output.

## Interface
- ID_WIDTH, 10, tid / channel width
- DATA_WIDTH, 32, tdata width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cntrl_en_i  in  1  run enable; stop is graceful (packet boundary)
- cntrl_min_length_i / cntrl_max_length_i  in  16  beat-count window
- cntrl_min_channel_i / cntrl_max_channel_i  in  ID_WIDTH  tid window
- cntrl_min_pause_i / cntrl_max_pause_i  in  32  inter-packet idle window (cycles)
- pkt_length_i  in  16  random length, new value every cycle
- pkt_channel_i  in  ID_WIDTH  random channel
- pkt_data_i  in  DATA_WIDTH  random data
- pkt_pause_i  in  32  random pause
- m_axis_tdata_o  out  DATA_WIDTH  beat data
- m_axis_tid_o  out  ID_WIDTH  packet channel
- m_axis_tlast_o  out  1  last beat
- m_axis_tvalid_o  out  1  beat valid
- m_axis_tready_i  in  1  sink ready
- busy_o  out  1  state != IDLE
- stat_pkt_cnt_o  out  32  packets completed (wraps)
- stat_beat_cnt_o  out  32  beats accepted (wraps)

## Operation
- FSM states: IDLE, LOAD, SEND, PAUSE.
- IDLE: tvalid=0. cntrl_en_i=1 -> LOAD.
- LOAD (one cycle): capture clamped length/channel/pause into registers; capture first beat data; -> SEND.
- Clamp rule (all three fields): v<min -> min; v>max -> max; else v. If min>max, result is max. Effective length = max(clamped length, 1).
- SEND: tvalid=1, tid = captured channel for the whole packet. Beat counter starts at 0; handshake = tvalid&tready. On handshake: count+1, stat_beat_cnt+1, tdata reloads from pkt_data_i. tlast=1 when count==len-1. Handshake on tlast: stat_pkt_cnt+1; pause==0 -> (en ? LOAD : IDLE); else -> PAUSE.
- PAUSE: down-counter loaded with pause; decrement each cycle; at 1 -> (en ? LOAD : IDLE). Pause of N gives exactly N cycles of tvalid=0 between the tlast handshake and the next LOAD.
- cntrl_en_i deassertion during LOAD/SEND/PAUSE does not truncate; honoured at the next decision point.
- Control window inputs are sampled only in LOAD; changes mid-packet have no effect.
- AXIS rules: once tvalid=1, tvalid, tdata, tid, tlast hold stable until handshake. tvalid never depends combinationally on tready.
- Reset (any time, including mid-packet): state IDLE, all outputs 0, counters 0, tvalid drops immediately.

## Timing
- en rises at cycle 0 (in IDLE) -> LOAD at cycle 1 -> tvalid=1 at cycle 2.
- Back-to-back with pause 0: tlast handshake at cycle t -> LOAD at t+1 -> next first beat valid at t+2 (one-cycle bubble, by design).
- Full throughput inside a packet: one beat per cycle while tready=1.
- All outputs registered; no input-to-output combinational path.

## Configuration
- GENAXIS_SEQ_DATA_EN defined: tdata = beat index (zero-extended or truncated to DATA_WIDTH), first beat 0, pkt_data_i ignored — for scoreboard-friendly debug.
- Undefined: tdata from pkt_data_i as described above.

## Structure
- genaxis_pkg: state enum typedef (IDLE, LOAD, SEND, PAUSE), stat counter width constant (32).
- Sub-module genaxis_clamp #(W): combinational min/max clamp, instantiated three times (length, channel, pause).

## Test plan
- min_len=max_len=4, pause 0, tready=1 -> packets of exactly 4 beats, tlast on beat 3, one idle cycle between packets, stat_pkt_cnt increments per packet.
- pkt_length_i forced 0, min_len=0 -> 1-beat packets with tlast on beat 0.
- min_len=5, max_len=2 -> every packet 2 beats; min_chan=3,max_chan=3 -> tid=3 always.
- tready random 50% -> tdata/tid/tlast stable across stalls; stat_beat_cnt equals sum of lengths.
- pause forced 7 -> exactly 7 tvalid=0 cycles after each tlast handshake before LOAD; en dropped mid-packet -> packet completes, then IDLE, busy_o=0.
- reset_n asserted mid-SEND -> tvalid=0 same cycle, counters 0, restart needs en; with GENAXIS_SEQ_DATA_EN, tdata sequence 0,1,2,… per packet.

Source files
------------

// File: rtl/genaxis_pkg.sv
// Shared types for the AXI-Stream packet former: FSM state encoding and statistics width.
package genaxis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam int STAT_W = 32;

endpackage

// File: rtl/genaxis_clamp.sv
// Combinational window clamp. An inverted window (min > max) collapses to max.
module genaxis_clamp #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] min_val,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] result
);

    always_comb begin
        result = value;
        if (min_val > max_val) begin
            result = max_val;
        end else if (value < min_val) begin
            result = min_val;
        end else if (value > max_val) begin
            result = max_val;
        end
    end

endmodule

// File: rtl/genaxis_pkt_former.sv
// Forms AXI-Stream packets from random descriptors, clamped to the programmed windows.
// Optional macro GENAXIS_SEQ_DATA_EN: tdata carries the beat index instead of pkt_data_i.
//
// state | meaning
// IDLE  | stopped, tvalid low, waiting for cntrl_en_i
// LOAD  | one cycle: capture clamped length/channel/pause and first beat data
// SEND  | beats presented under tready backpressure until tlast handshake
// PAUSE | inter-packet idle, down-counts the captured pause
module genaxis_pkt_former
    import genaxis_pkg::*;
#(
    parameter int ID_WIDTH   = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cntrl_en_i,
    input  logic [15:0]           cntrl_min_length_i,
    input  logic [15:0]           cntrl_max_length_i,
    input  logic [ID_WIDTH-1:0]   cntrl_min_channel_i,
    input  logic [ID_WIDTH-1:0]   cntrl_max_channel_i,
    input  logic [31:0]           cntrl_min_pause_i,
    input  logic [31:0]           cntrl_max_pause_i,
    input  logic [15:0]           pkt_length_i,
    input  logic [ID_WIDTH-1:0]   pkt_channel_i,
    input  logic [DATA_WIDTH-1:0] pkt_data_i,
    input  logic [31:0]           pkt_pause_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [ID_WIDTH-1:0]   m_axis_tid_o,
    output logic                  m_axis_tlast_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  busy_o,
    output logic [STAT_W-1:0]     stat_pkt_cnt_o,
    output logic [STAT_W-1:0]     stat_beat_cnt_o
);

    state_t                state, state_next;
    logic [15:0]           len_q;
    logic [15:0]           beat_cnt;
    logic [31:0]           pause_cnt;
    logic [ID_WIDTH-1:0]   tid_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tlast_q;
    logic                  tvalid_q;
    logic                  busy_q;
    logic [STAT_W-1:0]     stat_pkt_q;
    logic [STAT_W-1:0]     stat_beat_q;

    logic [15:0]           len_clamped;
    logic [15:0]           len_eff;
    logic [ID_WIDTH-1:0]   chan_clamped;
    logic [31:0]           pause_clamped;
    logic [DATA_WIDTH-1:0] first_data;
    logic [DATA_WIDTH-1:0] next_data;
    logic                  handshake;

    genaxis_clamp #(.W(16)) u_clamp_len (
        .value   (pkt_length_i),
        .min_val (cntrl_min_length_i),
        .max_val (cntrl_max_length_i),
        .result  (len_clamped)
    );

    genaxis_clamp #(.W(ID_WIDTH)) u_clamp_chan (
        .value   (pkt_channel_i),
        .min_val (cntrl_min_channel_i),
        .max_val (cntrl_max_channel_i),
        .result  (chan_clamped)
    );

    genaxis_clamp #(.W(32)) u_clamp_pause (
        .value   (pkt_pause_i),
        .min_val (cntrl_min_pause_i),
        .max_val (cntrl_max_pause_i),
        .result  (pause_clamped)
    );

    // A zero-length descriptor still produces a single-beat packet.
    assign len_eff   = (len_clamped == 16'd0) ? 16'd1 : len_clamped;
    assign handshake = tvalid_q & m_axis_tready_i;

`ifdef GENAXIS_SEQ_DATA_EN
    logic unused_pkt_data;
    assign unused_pkt_data = ^pkt_data_i;
    assign first_data      = '0;
    assign next_data       = DATA_WIDTH'(beat_cnt + 16'd1);
`else
    assign first_data = pkt_data_i;
    assign next_data  = pkt_data_i;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cntrl_en_i) state_next = LOAD;
            end
            LOAD: begin
                state_next = SEND;
            end
            SEND: begin
                if (handshake && tlast_q) begin
                    if (pause_cnt == 32'd0) state_next = cntrl_en_i ? LOAD : IDLE;
                    else                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_cnt <= 32'd1) state_next = cntrl_en_i ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output flags are computed from the next state so every port comes straight off a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            len_q       <= '0;
            beat_cnt    <= '0;
            pause_cnt   <= '0;
            tid_q       <= '0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            stat_pkt_q  <= '0;
            stat_beat_q <= '0;
        end else begin
            state    <= state_next;
            tvalid_q <= (state_next == SEND);
            busy_q   <= (state_next != IDLE);
            case (state)
                LOAD: begin
                    len_q     <= len_eff;
                    tid_q     <= chan_clamped;
                    pause_cnt <= pause_clamped;
                    beat_cnt  <= '0;
                    tlast_q   <= (len_eff == 16'd1);
                    tdata_q   <= first_data;
                end
                SEND: begin
                    if (handshake) begin
                        beat_cnt    <= beat_cnt + 16'd1;
                        stat_beat_q <= stat_beat_q + 1'b1;
                        tdata_q     <= next_data;
                        tlast_q     <= (beat_cnt + 16'd1 == len_q - 16'd1);
                        if (tlast_q) stat_pkt_q <= stat_pkt_q + 1'b1;
                    end
                end
                PAUSE: begin
                    pause_cnt <= pause_cnt - 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tid_o    = tid_q;
    assign m_axis_tlast_o  = tlast_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign busy_o          = busy_q;
    assign stat_pkt_cnt_o  = stat_pkt_q;
    assign stat_beat_cnt_o = stat_beat_q;

endmodule
